// File: rtl/ball_rx_packet_decoder.sv
// Receive side of the board-to-board ball hand-off: assembles I2C byte writes into a
// shadow packet, validates it and publishes it atomically. Define BALL_RX_CHECKSUM_EN to require an XOR byte at address 5.
`timescale 1ns/1ps
module ball_rx_packet_decoder #(
    parameter int unsigned TIMEOUT_CYC = 2500000,
    parameter int unsigned Y_MAX       = 480
) (
    input  logic       clk_25MHZ,
    input  logic       reset,
    input  logic       rx_valid,
    input  logic [2:0] rx_addr,
    input  logic [7:0] rx_data,
    input  logic       rx_stop,
    input  logic       game_start,
    input  logic       ball_accept,
    output logic [7:0] slv_reg0_y0,
    output logic [7:0] slv_reg1_y1,
    output logic [7:0] slv_reg2_Yspeed,
    output logic [7:0] slv_reg3_gravity,
    output logic [7:0] slv_reg4_ballspeed,
    output logic       go_left,
    output logic       responsing_i2c,
    output logic       pkt_error,
    output logic [1:0] err_code
);

`ifdef BALL_RX_CHECKSUM_EN
    localparam int NBYTES = 6;
`else
    localparam int NBYTES = 5;
`endif
    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [NBYTES-1:0] MASK_FULL = '1;

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_CHECK, S_LAUNCH} state_t;
    typedef enum logic [1:0] {ERR_ORDER, ERR_RANGE, ERR_TIMEOUT, ERR_OVERRUN} err_t;

    state_t            state_q, state_d;
    logic [7:0]        shadow_q [NBYTES];
    logic [7:0]        shadow_d [NBYTES];
    logic [NBYTES-1:0] mask_q, mask_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        slv_q [5];
    logic [7:0]        slv_d [5];
    logic              go_left_q, go_left_d;
    logic              busy_q, busy_d;
    logic              pkt_error_q, pkt_error_d;
    err_t              err_code_q, err_code_d;

    logic [2:0] next_addr;
    logic       addr_ok;
    logic [9:0] y_val;
    logic       range_ok;
    logic       sum_ok;
    logic       drop;
    err_t       drop_code;

    // Bytes arrive strictly in order, so the expected address is the lowest clear mask bit.
    always_comb begin
        next_addr = 3'(NBYTES);
        for (int i = NBYTES - 1; i >= 0; i--) begin
            if (!mask_q[i]) next_addr = 3'(i);
        end
    end

    assign addr_ok  = (mask_q != MASK_FULL) && (rx_addr == next_addr);
    assign y_val    = {shadow_q[1][1:0], shadow_q[0]};
    assign range_ok = ({22'd0, y_val} < Y_MAX) && (shadow_q[1][7:2] == 6'd0)
                      && (shadow_q[3] < 8'd4) && (shadow_q[4] != 8'd0);
`ifdef BALL_RX_CHECKSUM_EN
    assign sum_ok = (shadow_q[5] == (shadow_q[0] ^ shadow_q[1] ^ shadow_q[2] ^ shadow_q[3] ^ shadow_q[4]));
`else
    assign sum_ok = 1'b1;
`endif

    // NOTE: every *_d gets a default at the top so no path through the case infers a latch.
    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        mask_d      = mask_q;
        cnt_d       = cnt_q;
        slv_d       = slv_q;
        go_left_d   = go_left_q;
        pkt_error_d = 1'b0;
        err_code_d  = err_code_q;
        drop        = 1'b0;
        drop_code   = ERR_ORDER;

        unique case (state_q)
            S_IDLE: begin
                if (rx_valid && rx_addr == 3'd0 && game_start) begin
                    shadow_d[0] = rx_data;
                    mask_d      = NBYTES'(1);
                    cnt_d       = '0;
                    state_d     = S_RECV;
                end
            end
            S_RECV: begin
                if (!game_start) begin
                    mask_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    if (rx_valid) begin
                        if (addr_ok) begin
                            for (int i = 0; i < NBYTES; i++) begin
                                if (3'(i) == rx_addr) shadow_d[i] = rx_data;
                            end
                            mask_d = mask_q | (NBYTES'(1) << rx_addr);
                            cnt_d  = '0;
                        end else begin
                            drop = 1'b1;
                        end
                    end else if (!rx_stop) begin
                        if (cnt_q == CNT_LAST) begin
                            drop      = 1'b1;
                            drop_code = ERR_TIMEOUT;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    // A stop in the same cycle as a byte judges the mask including that byte.
                    if (rx_stop && !drop) begin
                        if (mask_d == MASK_FULL) state_d = S_CHECK;
                        else                     drop    = 1'b1;
                    end
                end
            end
            S_CHECK: begin
                mask_d = '0;
                if (!sum_ok) begin
                    drop      = 1'b1;
                    drop_code = ERR_OVERRUN;
                end else if (!range_ok) begin
                    drop      = 1'b1;
                    drop_code = ERR_RANGE;
                end else begin
                    for (int i = 0; i < 5; i++) slv_d[i] = shadow_q[i];
                    go_left_d = 1'b1;
                    state_d   = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (rx_valid) begin
                    pkt_error_d = 1'b1;
                    err_code_d  = ERR_OVERRUN;
                end
                if (ball_accept) begin
                    go_left_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (drop) begin
            pkt_error_d = 1'b1;
            err_code_d  = drop_code;
            mask_d      = '0;
            state_d     = S_IDLE;
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_25MHZ) begin
        if (reset) begin
            state_q     <= S_IDLE;
            mask_q      <= '0;
            cnt_q       <= '0;
            go_left_q   <= 1'b0;
            busy_q      <= 1'b0;
            pkt_error_q <= 1'b0;
            err_code_q  <= ERR_ORDER;
            for (int i = 0; i < NBYTES; i++) shadow_q[i] <= '0;
            for (int i = 0; i < 5; i++) slv_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            cnt_q       <= cnt_d;
            go_left_q   <= go_left_d;
            busy_q      <= busy_d;
            pkt_error_q <= pkt_error_d;
            err_code_q  <= err_code_d;
            shadow_q    <= shadow_d;
            slv_q       <= slv_d;
        end
    end

    assign slv_reg0_y0        = slv_q[0];
    assign slv_reg1_y1        = slv_q[1];
    assign slv_reg2_Yspeed    = slv_q[2];
    assign slv_reg3_gravity   = slv_q[3];
    assign slv_reg4_ballspeed = slv_q[4];
    assign go_left            = go_left_q;
    assign responsing_i2c     = busy_q;
    assign pkt_error          = pkt_error_q;
    assign err_code           = err_code_q;

endmodule

// File: tb/tb_ball_rx_packet_decoder.sv
// Self-checking bench for ball_rx_packet_decoder: directed cases plus random packets
// scored against a packet-level reference model. Honours BALL_RX_CHECKSUM_EN.
`timescale 1ns/1ps
module tb_ball_rx_packet_decoder;
    localparam int unsigned TIMEOUT_CYC = 32;
    localparam int unsigned Y_MAX       = 480;
`ifdef BALL_RX_CHECKSUM_EN
    localparam int NREQ = 6;
`else
    localparam int NREQ = 5;
`endif

    logic       clk_25MHZ   = 1'b0;
    logic       reset       = 1'b1;
    logic       rx_valid    = 1'b0;
    logic [2:0] rx_addr     = '0;
    logic [7:0] rx_data     = '0;
    logic       rx_stop     = 1'b0;
    logic       game_start  = 1'b1;
    logic       ball_accept = 1'b0;
    logic [7:0] slv_reg0_y0, slv_reg1_y1, slv_reg2_Yspeed, slv_reg3_gravity, slv_reg4_ballspeed;
    logic       go_left, responsing_i2c, pkt_error;
    logic [1:0] err_code;

    always #20 clk_25MHZ = ~clk_25MHZ;

    ball_rx_packet_decoder #(.TIMEOUT_CYC(TIMEOUT_CYC), .Y_MAX(Y_MAX)) dut (
        .clk_25MHZ          (clk_25MHZ),
        .reset              (reset),
        .rx_valid           (rx_valid),
        .rx_addr            (rx_addr),
        .rx_data            (rx_data),
        .rx_stop            (rx_stop),
        .game_start         (game_start),
        .ball_accept        (ball_accept),
        .slv_reg0_y0        (slv_reg0_y0),
        .slv_reg1_y1        (slv_reg1_y1),
        .slv_reg2_Yspeed    (slv_reg2_Yspeed),
        .slv_reg3_gravity   (slv_reg3_gravity),
        .slv_reg4_ballspeed (slv_reg4_ballspeed),
        .go_left            (go_left),
        .responsing_i2c     (responsing_i2c),
        .pkt_error          (pkt_error),
        .err_code           (err_code)
    );

    int checks   = 0;
    int errors   = 0;
    int err_seen = 0;

    // Every high cycle of pkt_error counts as one drop.
    always @(negedge clk_25MHZ) if (pkt_error === 1'b1) err_seen++;

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Packet-level reference model.
    bit         m_started;
    int         m_count;
    logic [7:0] m_buf [6];
    logic [7:0] exp_slv [5];
    bit         exp_go;
    int         exp_errs = 0;
    logic [1:0] exp_code;

    task automatic m_reset();
        m_started = 1'b0;
        m_count   = 0;
        exp_go    = 1'b0;
        exp_code  = 2'd0;
        for (int i = 0; i < 5; i++) exp_slv[i] = 8'h00;
    endtask

    function automatic bit range_ok();
        int y;
        y = int'(m_buf[1]) * 256 + int'(m_buf[0]);
        return (y < int'(Y_MAX)) && (m_buf[3] < 8'd4) && (m_buf[4] != 8'd0);
    endfunction

    function automatic bit sum_ok();
`ifdef BALL_RX_CHECKSUM_EN
        return m_buf[5] == (m_buf[0] ^ m_buf[1] ^ m_buf[2] ^ m_buf[3] ^ m_buf[4]);
`else
        return 1'b1;
`endif
    endfunction

    task automatic m_drop(input logic [1:0] c);
        exp_errs++;
        exp_code  = c;
        m_started = 1'b0;
    endtask

    task automatic m_byte(input logic [2:0] a, input logic [7:0] d);
        if (exp_go) begin
            exp_errs++;
            exp_code = 2'd3;
        end else if (!m_started) begin
            if (a == 3'd0 && game_start) begin
                m_started = 1'b1;
                m_count   = 1;
                m_buf[0]  = d;
            end
        end else if (int'(a) == m_count && m_count < NREQ) begin
            m_buf[m_count] = d;
            m_count++;
        end else begin
            m_drop(2'd0);
        end
    endtask

    task automatic m_stop();
        if (exp_go || !m_started) return;
        m_started = 1'b0;
        if (m_count != NREQ)  m_drop(2'd0);
        else if (!sum_ok())   m_drop(2'd3);
        else if (!range_ok()) m_drop(2'd1);
        else begin
            for (int i = 0; i < 5; i++) exp_slv[i] = m_buf[i];
            exp_go = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk_25MHZ);
        #1;
    endtask

    task automatic send_byte(input logic [2:0] a, input logic [7:0] d, input bit with_stop);
        rx_valid = 1'b1;
        rx_addr  = a;
        rx_data  = d;
        rx_stop  = with_stop;
        m_byte(a, d);
        if (with_stop) m_stop();
        tick();
        rx_valid = 1'b0;
        rx_stop  = 1'b0;
    endtask

    task automatic send_stop();
        rx_stop = 1'b1;
        m_stop();
        tick();
        rx_stop = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] b0, b1, b2, b3, b4, input bit bad_sum);
        logic [7:0] b [6];
        b = '{b0, b1, b2, b3, b4, b0 ^ b1 ^ b2 ^ b3 ^ b4 ^ (bad_sum ? 8'h01 : 8'h00)};
        for (int i = 0; i < NREQ; i++) send_byte(3'(i), b[i], 1'b0);
        send_stop();
    endtask

    task automatic compare_state(input string tag);
        repeat (3) tick();
        check({tag, ".errs"}, 32'(err_seen), 32'(exp_errs));
        check({tag, ".code"}, 32'(err_code), 32'(exp_code));
        check({tag, ".go"},   32'(go_left), 32'(exp_go));
        check({tag, ".busy"}, 32'(responsing_i2c), 32'(exp_go));
        check({tag, ".y0"},   32'(slv_reg0_y0), 32'(exp_slv[0]));
        check({tag, ".y1"},   32'(slv_reg1_y1), 32'(exp_slv[1]));
        check({tag, ".ysp"},  32'(slv_reg2_Yspeed), 32'(exp_slv[2]));
        check({tag, ".grav"}, 32'(slv_reg3_gravity), 32'(exp_slv[3]));
        check({tag, ".xsp"},  32'(slv_reg4_ballspeed), 32'(exp_slv[4]));
    endtask

    task automatic accept(input string tag);
        ball_accept = 1'b1;
        tick();
        ball_accept = 1'b0;
        exp_go = 1'b0;
        check({tag, ".acc_go"},   32'(go_left), 32'd0);
        check({tag, ".acc_busy"}, 32'(responsing_i2c), 32'd0);
    endtask

    initial begin
        int first;
        m_reset();
        repeat (3) tick();
        check("rst.pkt_error", 32'(pkt_error), 32'd0);
        reset = 1'b0;
        compare_state("rst");

        // Basic packet and its two-cycle publish latency.
        send_pkt(8'h2C, 8'h01, 8'hFD, 8'h02, 8'h04, 1'b0);
        check("t1.n1_go", 32'(go_left), 32'd0);
        check("t1.n1_busy", 32'(responsing_i2c), 32'd1);
        tick();
        check("t1.n2_go", 32'(go_left), 32'd1);
        check("t1.n2_y0", 32'(slv_reg0_y0), 32'h2C);
        check("t1.n2_y1", 32'(slv_reg1_y1), 32'h01);
        check("t1.n2_ysp", 32'(slv_reg2_Yspeed), 32'hFD);
        check("t1.n2_grav", 32'(slv_reg3_gravity), 32'h02);
        check("t1.n2_xsp", 32'(slv_reg4_ballspeed), 32'h04);
        compare_state("t1");
        accept("t1");

        // Out-of-order address.
        send_byte(3'd0, 8'h10, 1'b0);
        send_byte(3'd1, 8'h00, 1'b0);
        send_byte(3'd3, 8'h01, 1'b0);
        compare_state("order");
        check("order.code_c", 32'(err_code), 32'd0);
        check("order.keep_y0", 32'(slv_reg0_y0), 32'h2C);

        // Range boundaries.
        send_pkt(8'hE0, 8'h01, 8'h00, 8'h01, 8'h05, 1'b0);
        compare_state("y480");
        check("y480.code_c", 32'(err_code), 32'd1);
        send_pkt(8'hDF, 8'h01, 8'h00, 8'h01, 8'h05, 1'b0);
        compare_state("y479");
        accept("y479");
        send_pkt(8'h10, 8'h00, 8'h00, 8'h04, 8'h05, 1'b0);
        compare_state("grav4");
        send_pkt(8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        compare_state("speed0");
        send_pkt(8'h10, 8'h04, 8'h00, 8'h00, 8'h05, 1'b0);
        compare_state("y1hi");

        // Early stop.
        for (int i = 0; i < 4; i++) send_byte(3'(i), 8'h01, 1'b0);
        send_stop();
        compare_state("early");

`ifdef BALL_RX_CHECKSUM_EN
        send_pkt(8'h2C, 8'h01, 8'hFD, 8'h02, 8'h04, 1'b1);
        compare_state("sum_bad");
        check("sum_bad.code_c", 32'(err_code), 32'd3);
        send_pkt(8'hE0, 8'h01, 8'h00, 8'h01, 8'h05, 1'b1);
        compare_state("sum_prio");
`else
        for (int i = 0; i < 5; i++) send_byte(3'(i), 8'h01, 1'b0);
        send_byte(3'd5, 8'h01, 1'b0);
        send_stop();
        compare_state("addr5");
`endif

        // Inter-byte timeout.
        send_byte(3'd0, 8'h11, 1'b0);
        send_byte(3'd1, 8'h00, 1'b0);
        send_byte(3'd2, 8'h22, 1'b0);
        first = 0;
        for (int k = 1; k <= int'(TIMEOUT_CYC) + 2; k++) begin
            tick();
            if (pkt_error === 1'b1 && first == 0) first = k;
        end
        check("timeout.cycle", 32'(first), 32'(TIMEOUT_CYC));
        m_drop(2'd2);
        compare_state("timeout");

        // Byte during LAUNCH, then reset in the middle of a packet.
        send_pkt(8'h33, 8'h00, 8'h81, 8'h03, 8'h07, 1'b0);
        compare_state("launch");
        send_byte(3'd0, 8'hAA, 1'b0);
        compare_state("stray");
        accept("stray");
        send_byte(3'd0, 8'h44, 1'b0);
        send_byte(3'd1, 8'h00, 1'b0);
        reset = 1'b1;
        tick();
        check("midrst.go", 32'(go_left), 32'd0);
        check("midrst.busy", 32'(responsing_i2c), 32'd0);
        check("midrst.pkt_error", 32'(pkt_error), 32'd0);
        check("midrst.code", 32'(err_code), 32'd0);
        check("midrst.y0", 32'(slv_reg0_y0), 32'd0);
        check("midrst.xsp", 32'(slv_reg4_ballspeed), 32'd0);
        reset = 1'b0;
        m_reset();
        compare_state("post_rst");

        // game_start falling mid-packet aborts silently.
        send_byte(3'd0, 8'h05, 1'b0);
        send_byte(3'd1, 8'h00, 1'b0);
        game_start = 1'b0;
        tick();
        check("gs.busy", 32'(responsing_i2c), 32'd0);
        m_started = 1'b0;
        send_byte(3'd0, 8'h05, 1'b0);
        game_start = 1'b1;
        for (int i = 2; i < NREQ; i++) send_byte(3'(i), 8'h01, 1'b0);
        send_stop();
        compare_state("gs");

        // Random packets.
        for (int t = 0; t < 80; t++) begin
            int kind;
            int n;
            int bad_pos;
            bit merge;
            logic [2:0] a;
            logic [7:0] b [6];
            kind = int'($urandom_range(0, 3));
            b[0] = 8'($urandom);
            b[1] = 8'($urandom_range(0, 1));
            b[2] = 8'($urandom);
            b[3] = 8'($urandom_range(0, 3));
            b[4] = 8'($urandom_range(1, 255));
            if (kind == 1) b[$urandom_range(0, 4)] = 8'($urandom);
            b[5] = b[0] ^ b[1] ^ b[2] ^ b[3] ^ b[4];
            if (kind == 1 && $urandom_range(0, 2) == 0) b[5] = 8'($urandom);
            n       = (kind == 3) ? int'($urandom_range(1, NREQ - 1)) : NREQ;
            bad_pos = (kind == 2) ? int'($urandom_range(0, NREQ - 1)) : 99;
            if ($urandom_range(0, 4) == 0) begin
                ball_accept = 1'b1;
                tick();
                ball_accept = 1'b0;
            end
            merge = 1'b0;
            for (int i = 0; i < n; i++) begin
                a     = (i == bad_pos) ? 3'($urandom_range(0, 7)) : 3'(i);
                merge = (i == n - 1) && m_started && ($urandom_range(0, 1) == 1);
                send_byte(a, b[i], merge);
                if (i < n - 1) repeat ($urandom_range(0, 3)) tick();
            end
            if (!merge) begin
                repeat ($urandom_range(0, 3)) tick();
                send_stop();
            end
            compare_state($sformatf("rnd%0d", t));
            if (exp_go) begin
                if ($urandom_range(0, 1) == 1) begin
                    send_byte(3'($urandom_range(0, 7)), 8'($urandom), 1'b0);
                    compare_state($sformatf("rnd%0d.stray", t));
                end
                repeat ($urandom_range(0, 3)) tick();
                accept($sformatf("rnd%0d", t));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
